cap_charge_ctrl: RTL and testbench
==================================

Name: cap_charge_ctrl

Overview:
- Digital charge/discharge controller that sits around the capacitor model stage.
- Consumes the sampled capacitor voltage as an unsigned code with a valid strobe, and produces the signed current command that drives the capacitor stage.
- Runs a hysteretic triangle-wave loop: charge to V_HI, settle, discharge to V_LO, settle, repeat.
- Counts completed cycles and flags a fault when a threshold is never reached.

Parameters:
- VW, 16, width of the voltage code (unsigned).
- IW, 12, width of the current command (two's complement).
- V_HI, 40000, upper threshold code; charging stops when v_code >= V_HI.
- V_LO, 10000, lower threshold code; discharging stops when v_code <= V_LO. V_LO < V_HI is required and checked by an elaboration-time assertion.
- I_CHG, 100, positive charge current code.
- I_DIS, -100, negative discharge current code.
- SETTLE, 4, number of clk cycles spent in each hold state (>= 1).
- TMO, 50000, maximum number of clk cycles allowed in CHARGE or DISCHARGE before a fault.

Ports:
- clk  in  1  sampling clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  loop enable, level-sensitive.
- v_valid  in  1  v_code is a fresh sample this cycle.
- v_code  in  VW  sampled capacitor voltage, unsigned.
- i_code  out  IW  signed current command to the capacitor stage.
- i_valid  out  1  high whenever i_code is a live drive value (CHARGE or DISCHARGE).
- state  out  3  encoded FSM state, for debug and bench use.
- cycle_cnt  out  16  completed charge/discharge cycles, saturating.
- cnt_sat  out  1  sticky; set when cycle_cnt saturates.
- fault  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, i_code=0, i_valid=0, cycle_cnt=0, cnt_sat=0, fault=0.
  - Timers are cleared.
  - Asserting rst mid-operation forces these values immediately, without waiting for a clk edge.
- Outputs: all outputs are registered. A state decided at edge N is visible on i_code after edge N, so latency from a qualifying sample to the changed i_code is 1 cycle.
- State encoding: IDLE=0, CHARGE=1, HOLD_HI=2, DISCHARGE=3, HOLD_LO=4, FAULT=5.
- Per-state outputs:
  - IDLE: i_code=0, i_valid=0. If en=1, go to CHARGE on the next edge. cycle_cnt is not cleared.
  - CHARGE: i_code=I_CHG, i_valid=1. When v_valid=1 and v_code >= V_HI, go to HOLD_HI. Samples with v_valid=0 are ignored.
  - HOLD_HI: i_code=0, i_valid=0. Stays exactly SETTLE cycles, then goes to DISCHARGE. v_code is ignored.
  - DISCHARGE: i_code=I_DIS, i_valid=1. When v_valid=1 and v_code <= V_LO, go to HOLD_LO.
  - HOLD_LO: i_code=0, i_valid=0. Stays SETTLE cycles, then goes to CHARGE.
    - On that exit, cycle_cnt increments.
    - At 16'hFFFF it holds and sets cnt_sat instead of wrapping.
  - FAULT: i_code=0, i_valid=0, fault=1. Leaves only when en=0, going to IDLE. fault stays set until rst.
- Timeout:
  - A single drive timer clears on entry to CHARGE or DISCHARGE and counts every cycle in that state.
  - When it reaches TMO-1 without a crossing, go to FAULT.
  - If a crossing and the timeout occur in the same cycle, the crossing wins.
- Priority, highest first: rst > en=0 > threshold crossing > timeout > hold timer.
  - en=0 in any state except IDLE gives IDLE on the next edge, with i_code=0.
  - Re-enabling always restarts from CHARGE, whatever the voltage.
- Boundaries:
  - v_code exactly equal to V_HI or V_LO counts as a crossing.
  - If v_code is already >= V_HI on entry to CHARGE, the first valid sample exits immediately; one cycle of I_CHG is still driven.
  - The threshold compare is unsigned, at full VW width.
  - The hold timer is sized as clog2(SETTLE+1); the drive timer as clog2(TMO+1).

Decomposition:
- Package cap_ctrl_pkg:
  - state_t enum with the encoding above.
  - Constants CNT_W=16 and STATE_W=3.
  - Default threshold and current codes, shared with the bench.
- One natural sub-module: cap_ctrl_timer, a loadable down-counter with clear and a done pulse. It is instantiated twice, once for hold and once for drive timeout.
- The FSM and cycle counter live in cap_charge_ctrl.

Test Plan:
- Reset/idle: rst=1 mid-CHARGE -> same cycle i_code=0, i_valid=0, state=0, cycle_cnt=0. With rst=0 and en=0 for 20 cycles -> state stays 0.
- Nominal cycle:
  - Stimulus: en=1; bench models v += i_code each valid cycle, starting at v=0, with defaults.
  - Response: i_code=100 until the sample reaching 40000; then i_code=0 for exactly 4 cycles; then -100 down to 10000; then 0 for 4 cycles; then cycle_cnt=1 and i_code=100.
- Threshold equality and gating:
  - v_code=40000 with v_valid=0 -> remains CHARGE.
  - Same value with v_valid=1 -> HOLD_HI after 1 edge.
  - v_code=10000 in DISCHARGE -> HOLD_LO.
- Timeout: en=1, v_code held at 0 -> after 50000 cycles state=5, fault=1, i_code=0. Then en=0 -> IDLE, fault still 1 until rst.
- Enable drop mid-DISCHARGE: en=0 -> next edge state=0, i_code=0. Then en=1 -> CHARGE, i_code=100, cycle_cnt unchanged.
- Saturation: run with force-preloaded cycle_cnt=16'hFFFE through 2 cycles -> cycle_cnt=16'hFFFF, cnt_sat=1, no wrap.

Source files
------------

// File: rtl/cap_ctrl_pkg.sv
// cap_ctrl_pkg: shared state encoding, widths and default codes for the capacitor charge controller
package cap_ctrl_pkg;
  localparam int CNT_W = 16;
  localparam int STATE_W = 3;
  localparam int DEF_V_HI = 40000;
  localparam int DEF_V_LO = 10000;
  localparam int DEF_I_CHG = 100;
  localparam int DEF_I_DIS = -100;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_TMO = 50000;
  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    CHARGE    = 3'd1,
    HOLD_HI   = 3'd2,
    DISCHARGE = 3'd3,
    HOLD_LO   = 3'd4,
    FAULT     = 3'd5
  } state_t;
  function automatic logic is_drive(state_t s);
    return s == CHARGE || s == DISCHARGE;
  endfunction
  function automatic logic is_hold(state_t s);
    return s == HOLD_HI || s == HOLD_LO;
  endfunction
endpackage

// File: rtl/cap_ctrl_timer.sv
// cap_ctrl_timer: loadable down-counter with clear; done is high while running at zero
//   clk, rst : clock, async active-high reset
//   clr      : force count to zero (wins over load)
//   load/val : preload the count
//   run      : count down while high
//   done     : run && count == 0
module cap_ctrl_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= val;
    else if (run && cnt != '0) cnt <= cnt - 1'b1;
  assign done = run && cnt == '0;
endmodule

// File: rtl/cap_charge_ctrl.sv
// cap_charge_ctrl: hysteretic triangle-wave charge/discharge controller for the capacitor stage
//   clk, rst   : clock, async active-high reset
//   en         : loop enable (level)
//   v_valid    : v_code holds a fresh sample
//   v_code     : unsigned capacitor voltage code
//   i_code     : signed current command (registered)
//   i_valid    : i_code is a live drive value
//   state      : encoded FSM state
//   cycle_cnt  : completed cycles, saturating; cnt_sat sticky on saturation
//   fault      : sticky drive timeout
module cap_charge_ctrl
  import cap_ctrl_pkg::*;
#(
  parameter int VW = 16,
  parameter int IW = 12,
  parameter logic [VW-1:0] V_HI = VW'(DEF_V_HI),
  parameter logic [VW-1:0] V_LO = VW'(DEF_V_LO),
  parameter logic [IW-1:0] I_CHG = IW'(DEF_I_CHG),
  parameter logic [IW-1:0] I_DIS = IW'(DEF_I_DIS),
  parameter int SETTLE = DEF_SETTLE,
  parameter int TMO = DEF_TMO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               v_valid,
  input  logic [VW-1:0]      v_code,
  output logic [IW-1:0]      i_code,
  output logic               i_valid,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic               cnt_sat,
  output logic               fault
);
  localparam int HW = $clog2(SETTLE + 1);
  localparam int DW = $clog2(TMO + 1);
  if (V_LO >= V_HI) begin : g_bad_thr
    $error("cap_charge_ctrl: V_LO must be below V_HI");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("cap_charge_ctrl: SETTLE must be at least 1");
  end
  state_t st, nx;
  logic hi_hit, lo_hit, hold_done, drv_done, wrap, iv_nx;
  logic [IW-1:0] i_nx;
  assign hi_hit = v_valid && v_code >= V_HI;
  assign lo_hit = v_valid && v_code <= V_LO;
  // Timers preload while outside their active states, so each starts full on entry.
  cap_ctrl_timer #(.W(HW)) u_hold (
    .clk(clk), .rst(rst), .clr(!en), .load(!is_hold(st)), .run(is_hold(st)),
    .val(HW'(SETTLE - 1)), .done(hold_done)
  );
  cap_ctrl_timer #(.W(DW)) u_drive (
    .clk(clk), .rst(rst), .clr(!en), .load(!is_drive(st)), .run(is_drive(st)),
    .val(DW'(TMO - 1)), .done(drv_done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nx;
  // Crossing is tested before timeout so a simultaneous crossing wins.
  always_comb begin
    nx = st;
    if (!en) nx = IDLE;
    else
      case (st)
        IDLE:      nx = CHARGE;
        CHARGE:    nx = hi_hit ? HOLD_HI : drv_done ? FAULT : CHARGE;
        HOLD_HI:   nx = hold_done ? DISCHARGE : HOLD_HI;
        DISCHARGE: nx = lo_hit ? HOLD_LO : drv_done ? FAULT : DISCHARGE;
        HOLD_LO:   nx = hold_done ? CHARGE : HOLD_LO;
        default:   nx = FAULT;
      endcase
    i_nx = nx == CHARGE ? I_CHG : nx == DISCHARGE ? I_DIS : '0;
    iv_nx = is_drive(nx);
  end
  assign wrap = en && st == HOLD_LO && hold_done;
  assign state = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i_code <= '0;
      i_valid <= 1'b0;
      cycle_cnt <= '0;
      cnt_sat <= 1'b0;
      fault <= 1'b0;
    end else begin
      i_code <= i_nx;
      i_valid <= iv_nx;
      if (nx == FAULT) fault <= 1'b1;
      if (wrap) begin
        if (&cycle_cnt) cnt_sat <= 1'b1;
        else cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_cap_charge_ctrl.sv
// tb_cap_charge_ctrl: scoreboard bench for cap_charge_ctrl against a cycle model of the loop
module tb_cap_charge_ctrl;
  import cap_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, v_valid = 1'b0;
  logic [15:0] v_code = '0;
  logic [11:0] i_code;
  logic i_valid, cnt_sat, fault;
  logic [2:0] state;
  logic [15:0] cycle_cnt;
  cap_charge_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .v_valid(v_valid), .v_code(v_code),
    .i_code(i_code), .i_valid(i_valid), .state(state),
    .cycle_cnt(cycle_cnt), .cnt_sat(cnt_sat), .fault(fault)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] i;
    logic        iv;
    logic [2:0]  st;
    logic [15:0] cnt;
    logic        sat;
    logic        f;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0;
  int m_st = 0, m_d = 0, m_h = 0, v = 0;
  logic [15:0] m_cnt = '0;
  logic m_sat = 1'b0, m_f = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] icode_of(input int s);
    return s == 1 ? 12'(DEF_I_CHG) : s == 3 ? 12'(DEF_I_DIS) : 12'd0;
  endfunction
  task automatic model_reset();
    m_st = 0; m_d = 0; m_h = 0; m_cnt = '0; m_sat = 1'b0; m_f = 1'b0;
  endtask
  task automatic step(input logic e, input logic vv, input logic [15:0] vc);
    exp_t x;
    int nx;
    @(negedge clk);
    en = e; v_valid = vv; v_code = vc;
    if (!e) nx = 0;
    else
      case (m_st)
        0: nx = 1;
        1: nx = (vv && int'(vc) >= DEF_V_HI) ? 2 : (m_d == DEF_TMO - 1) ? 5 : 1;
        2: nx = (m_h == DEF_SETTLE - 1) ? 3 : 2;
        3: nx = (vv && int'(vc) <= DEF_V_LO) ? 4 : (m_d == DEF_TMO - 1) ? 5 : 3;
        4: nx = (m_h == DEF_SETTLE - 1) ? 1 : 4;
        default: nx = 5;
      endcase
    if (e && m_st == 4 && nx == 1) begin
      if (m_cnt == 16'hFFFF) m_sat = 1'b1;
      else m_cnt++;
    end
    if (nx == 5) m_f = 1'b1;
    if (nx != m_st) begin m_d = 0; m_h = 0; end
    else begin m_d++; m_h++; end
    m_st = nx;
    x.i = icode_of(nx); x.iv = (nx == 1 || nx == 3); x.st = 3'(nx);
    x.cnt = m_cnt; x.sat = m_sat; x.f = m_f;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("i_code", 32'(i_code), 32'(x.i));
    check("i_valid", 32'(i_valid), 32'(x.iv));
    check("state", 32'(state), 32'(x.st));
    check("cycle_cnt", 32'(cycle_cnt), 32'(x.cnt));
    check("cnt_sat", 32'(cnt_sat), 32'(x.sat));
    check("fault", 32'(fault), 32'(x.f));
  endtask
  task automatic nominal(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b1, 16'(v));
      v += int'($signed(icode_of(m_st)));
    end
  endtask
  task automatic run_cycle();
    step(1'b1, 1'b1, 16'd40000);
    check("early_exit_hold_hi", 32'(state), 32'd2);
    for (int k = 0; k < DEF_SETTLE; k++) step(1'b1, 1'b1, 16'd40000);
    step(1'b1, 1'b1, 16'd10000);
    for (int k = 0; k < DEF_SETTLE; k++) step(1'b1, 1'b1, 16'd10000);
  endtask
  initial begin
    int k;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_i_code", 32'(i_code), 32'd0);
    check("rst_i_valid", 32'(i_valid), 32'd0);
    check("rst_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_sat", 32'(cnt_sat), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 20; j++) step(1'b0, 1'b0, 16'd0);
    check("idle_hold", 32'(state), 32'd0);
    v = 0;
    nominal(1500);
    check("two_cycles", 32'(cycle_cnt), 32'd2);
    k = 0;
    while (m_st != 3 && k < 2000) begin nominal(1); k++; end
    step(1'b1, 1'b1, 16'(v));
    check("in_discharge", 32'(state), 32'd3);
    step(1'b0, 1'b1, 16'(v));
    check("drop_state", 32'(state), 32'd0);
    check("drop_i_code", 32'(i_code), 32'd0);
    step(1'b1, 1'b1, 16'(v));
    check("reen_state", 32'(state), 32'd1);
    check("reen_i_code", 32'(i_code), 32'd100);
    check("reen_cnt", 32'(cycle_cnt), 32'd2);
    step(1'b1, 1'b0, 16'd40000);
    check("gated_hi", 32'(state), 32'd1);
    step(1'b1, 1'b1, 16'd40000);
    check("eq_hi", 32'(state), 32'd2);
    for (int j = 0; j < DEF_SETTLE; j++) step(1'b1, 1'b1, 16'd0);
    check("to_discharge", 32'(state), 32'd3);
    step(1'b1, 1'b0, 16'd10000);
    check("gated_lo", 32'(state), 32'd3);
    step(1'b1, 1'b1, 16'd10000);
    check("eq_lo", 32'(state), 32'd4);
    for (int j = 0; j < DEF_SETTLE; j++) step(1'b1, 1'b1, 16'd60000);
    check("cnt3", 32'(cycle_cnt), 32'd3);
    step(1'b1, 1'b1, 16'd20000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_i_code", 32'(i_code), 32'd0);
    check("arst_i_valid", 32'(i_valid), 32'd0);
    check("arst_cnt", 32'(cycle_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 16'd20000);
    @(negedge clk);
    force dut.cycle_cnt = 16'hFFFE;
    #1;
    release dut.cycle_cnt;
    m_cnt = 16'hFFFE;
    run_cycle();
    check("sat1_cnt", 32'(cycle_cnt), 32'hFFFF);
    check("sat1_flag", 32'(cnt_sat), 32'd0);
    run_cycle();
    check("sat2_cnt", 32'(cycle_cnt), 32'hFFFF);
    check("sat2_flag", 32'(cnt_sat), 32'd1);
    k = 0;
    while (state != 3'd5 && k < DEF_TMO + 10) begin step(1'b1, 1'b1, 16'd0); k++; end
    check("tmo_len", 32'(k), 32'(DEF_TMO));
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_i_code", 32'(i_code), 32'd0);
    step(1'b0, 1'b1, 16'd0);
    check("flt_idle", 32'(state), 32'd0);
    check("flt_sticky", 32'(fault), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("flt_clear", 32'(fault), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
